// File: rtl/eval_stack_pkg.sv
// rtl/eval_stack_pkg.sv - shared op encodings and sizing helper for the evaluation stack
package eval_stack_pkg;

    // Op codes are the concatenation {push, pop, load}
    localparam logic [2:0] ST_OP_NONE  = 3'b000;
    localparam logic [2:0] ST_OP_LOAD  = 3'b001;
    localparam logic [2:0] ST_OP_POP   = 3'b010;
    localparam logic [2:0] ST_OP_POPL  = 3'b011;
    localparam logic [2:0] ST_OP_PUSH  = 3'b100;
    localparam logic [2:0] ST_OP_PUSHL = 3'b101;
    localparam logic [2:0] ST_OP_PP    = 3'b110;
    localparam logic [2:0] ST_OP_PPL   = 3'b111;

    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/eval_stack_stack_ctr.sv
// rtl/eval_stack_stack_ctr.sv - occupancy, error flags, trap arm and high-water mark
module stack_ctr
    import eval_stack_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TRAP_EN = 1,
    parameter int CW      = clog2_depth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    op,
    input  logic          err_clr,
    input  logic          hwm_clr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic          err_trap,
    output logic [CW-1:0] hwm
);

    logic [CW-1:0] count_nxt;
    logic [CW-1:0] hwm_nxt;
    logic          ovf_set;
    logic          unf_set;
    logic          err_new;
    logic          armed;

    always_comb begin
        count_nxt = count;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (op)
            ST_OP_PUSH, ST_OP_PUSHL: begin
                if (count == CW'(DEPTH)) ovf_set = 1'b1;
                else                     count_nxt = count + 1'b1;
            end
            ST_OP_POP: begin
                if (count == '0) unf_set = 1'b1;
                else             count_nxt = count - 1'b1;
            end
            // Binary-op form: a pop from one entry with a load leaves one entry
            ST_OP_POPL: begin
                if (count == '0)                unf_set = 1'b1;
                else if (count != CW'(1))       count_nxt = count - 1'b1;
            end
            ST_OP_LOAD: begin
                if (count == '0) count_nxt = CW'(1);
            end
            ST_OP_NONE, ST_OP_PP, ST_OP_PPL: ;
            default: ;
        endcase
        err_new = ovf_set | unf_set;
        if (hwm_clr)              hwm_nxt = count_nxt;
        else if (count_nxt > hwm) hwm_nxt = count_nxt;
        else                      hwm_nxt = hwm;
    end

    // A new error beats err_clr on the flag; err_clr always re-arms the trap
    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            err_trap <= 1'b0;
            armed    <= 1'b1;
            hwm      <= '0;
        end else begin
            count    <= count_nxt;
            ovf      <= ovf_set | (ovf & ~err_clr);
            unf      <= unf_set | (unf & ~err_clr);
            err_trap <= (TRAP_EN != 0) && err_new && armed;
            armed    <= err_clr | (armed & ~err_new);
            hwm      <= hwm_nxt;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/eval_stack.sv
// rtl/eval_stack.sv - evaluation stack with combined pop/push/load, peek port and error tracking
module eval_stack
    import eval_stack_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int TRAP_EN = 1,
    parameter int IW      = $clog2(DEPTH),
    parameter int CW      = clog2_depth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop,
    input  logic             push,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data0,
    output logic [WIDTH-1:0] data1,
    input  logic [IW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             err_trap,
    input  logic             err_clr,
    output logic [CW-1:0]    hwm,
    input  logic             hwm_clr
);

    logic [WIDTH-1:0] stk [DEPTH];
    logic [2:0]       op;

    assign op = {push, pop, load};

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else begin
            case (op)
                ST_OP_PUSH, ST_OP_PUSHL: begin
                    for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
                    if (load) stk[0] <= data_in;
                end
                // Shift runs even on underflow; the tail refills with zeros
                ST_OP_POP, ST_OP_POPL: begin
                    for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                    stk[DEPTH-1] <= '0;
                    if (load) stk[0] <= data_in;
                end
                ST_OP_LOAD, ST_OP_PPL: stk[0] <= data_in;
                ST_OP_NONE, ST_OP_PP: ;
                default: ;
            endcase
        end
    end

    assign data0 = stk[0];
    assign data1 = stk[1];

    always_comb begin
        peek_data = '0;
        if (32'(peek_idx) < DEPTH) peek_data = stk[peek_idx];
    end

    stack_ctr #(
        .DEPTH   (DEPTH),
        .TRAP_EN (TRAP_EN),
        .CW      (CW)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .err_clr  (err_clr),
        .hwm_clr  (hwm_clr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .unf      (unf),
        .err_trap (err_trap),
        .hwm      (hwm)
    );

endmodule

// File: tb/tb_eval_stack.sv
// tb/tb_eval_stack.sv - randomized and directed checks of eval_stack against a behavioural model
module tb_eval_stack;

    localparam int W = 16;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst, pop, push, load, err_clr, hwm_clr;
    logic [W-1:0]  data_in;
    logic [1:0]    peek_idx;
    logic [W-1:0]  data0, data1, peek_data;
    logic [2:0]    count, hwm;
    logic          full, empty, ovf, unf, err_trap;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    int m_stk [D];
    int m_count, m_hwm;
    bit m_ovf, m_unf, m_trap, m_armed;

    always #5 clk = ~clk;

    eval_stack #(.WIDTH(W), .DEPTH(D), .TRAP_EN(1)) dut (
        .clk(clk), .rst(rst), .pop(pop), .push(push), .load(load),
        .data_in(data_in), .data0(data0), .data1(data1),
        .peek_idx(peek_idx), .peek_data(peek_data), .count(count),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf),
        .err_trap(err_trap), .err_clr(err_clr), .hwm(hwm), .hwm_clr(hwm_clr)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Stack semantics as a list: index 0 is the top of stack
    task automatic model_step();
        int old [D];
        bit err;
        err = 1'b0;
        if (!rst) begin
            for (int i = 0; i < D; i++) m_stk[i] = 0;
            m_count = 0; m_hwm = 0;
            m_ovf = 0; m_unf = 0; m_trap = 0; m_armed = 1;
            return;
        end
        old = m_stk;
        if (push && !pop) begin
            for (int i = 1; i < D; i++) m_stk[i] = old[i-1];
            m_stk[0] = load ? int'(data_in) : old[0];
            if (m_count == D) err = 1'b1; else m_count++;
            if (err) begin m_ovf = 1; end else if (err_clr) m_ovf = 0;
            if (err_clr) m_unf = 0;
        end else if (pop && !push) begin
            for (int i = 0; i < D - 1; i++) m_stk[i] = old[i+1];
            m_stk[D-1] = 0;
            if (load) m_stk[0] = int'(data_in);
            if (m_count == 0) err = 1'b1;
            else m_count = (load && m_count == 1) ? 1 : m_count - 1;
            if (err) begin m_unf = 1; end else if (err_clr) m_unf = 0;
            if (err_clr) m_ovf = 0;
        end else begin
            if (load) m_stk[0] = int'(data_in);
            if (load && !push && !pop && m_count == 0) m_count = 1;
            if (err_clr) begin m_ovf = 0; m_unf = 0; end
        end
        m_trap = err && m_armed;
        if (err_clr) m_armed = 1; else if (err) m_armed = 0;
        if (hwm_clr) m_hwm = m_count;
        else if (m_count > m_hwm) m_hwm = m_count;
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input bit ld,
                        input int din, input int pk, input bit ec, input bit hc);
        rst = r; push = pu; pop = po; load = ld;
        data_in = W'(din); peek_idx = 2'(pk); err_clr = ec; hwm_clr = hc;
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("data0", int'(data0), m_stk[0]);
            check("data1", int'(data1), m_stk[1]);
            check("peek_data", int'(peek_data), m_stk[peek_idx]);
            check("count", int'(count), m_count);
            check("full", int'(full), int'(m_count == D));
            check("empty", int'(empty), int'(m_count == 0));
            check("ovf", int'(ovf), int'(m_ovf));
            check("unf", int'(unf), int'(m_unf));
            check("err_trap", int'(err_trap), int'(m_trap));
            check("hwm", int'(hwm), m_hwm);
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);

        // push 1,2,3 with load
        for (int v = 1; v <= 3; v++) step(1, 1, 0, 1, v, 2, 0, 0);
        check("t1_data0", int'(data0), 3);
        check("t1_data1", int'(data1), 2);
        check("t1_count", int'(count), 3);
        check("t1_peek2", int'(peek_data), 1);
        check("t1_empty", int'(empty), 0);

        step(1, 0, 1, 1, 5, 0, 0, 0);
        check("t2_data0", int'(data0), 5);
        check("t2_data1", int'(data1), 1);
        check("t2_count", int'(count), 2);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        check("t2_empty", int'(empty), 1);
        check("t2_unf", int'(unf), 0);

        // overflow with five pushes into four entries
        for (int v = 10; v <= 14; v++) step(1, 1, 0, 1, v, 3, 0, 0);
        check("t3_count", int'(count), 4);
        check("t3_full", int'(full), 1);
        check("t3_ovf", int'(ovf), 1);
        check("t3_trap", int'(err_trap), 1);
        check("t3_peek3", int'(peek_data), 11);
        step(1, 0, 0, 0, 0, 3, 0, 0);
        check("t3_trap_off", int'(err_trap), 0);

        // underflow trap arming
        step(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0, 0, 0);
        check("t4_no_trap", int'(err_trap), 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        check("t4_unf", int'(unf), 1);
        check("t4_trap1", int'(err_trap), 1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        check("t4_trap2", int'(err_trap), 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        check("t4_trap3", int'(err_trap), 1);

        // push&pop&load acts as a plain top write
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 2, 0, 0, 0);
        step(1, 1, 1, 1, 7, 0, 0, 0);
        check("t5_data0", int'(data0), 7);
        check("t5_data1", int'(data1), 1);
        check("t5_count", int'(count), 2);
        check("t5_flags", int'({ovf, unf, err_trap}), 0);

        // high-water mark, then reset mid-sequence
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 20 + i, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        check("t6_hwm", int'(hwm), 3);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        check("t6_hwm_clr", int'(hwm), 1);
        step(1, 1, 0, 1, 9, 0, 0, 0);
        step(0, 1, 0, 1, 9, 0, 0, 0);
        check("t6_rst_count", int'(count), 0);
        check("t6_rst_data0", int'(data0), 0);
        check("t6_rst_hwm", int'(hwm), 0);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 60) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eval_stack.md
Name: eval_stack

Overview:
- Parametrised evaluation-stack unit for the next-generation stack-machine core. Replaces the fixed operand stack and call stack instances.
- Holds DEPTH entries of WIDTH bits. Supports combined pop/push/load in one cycle, as the core's control signals issue them.
- Adds what the current stack lacks: occupancy tracking, full/empty flags, sticky overflow/underflow detection with a one-shot trap request, an arbitrary-depth peek port, and a high-water mark for firmware stack sizing.

Parameters:
- WIDTH, 16, entry width in bits.
- DEPTH, 16, number of entries; must be ≥ 2.
- TRAP_EN, 1, 1 = drive err_trap on the first error; 0 = err_trap tied 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at a clk rising edge).
- pop  in  1  shift entries toward the top (stk[i] <= stk[i+1]).
- push  in  1  shift entries toward the bottom (stk[i+1] <= stk[i]).
- load  in  1  write data_in into stk[0] after any shift.
- data_in  in  WIDTH  value for stk[0].
- data0  out  WIDTH  stk[0], combinational from the register.
- data1  out  WIDTH  stk[1], combinational from the register.
- peek_idx  in  $clog2(DEPTH)  index for the peek read.
- peek_data  out  WIDTH  stk[peek_idx]; 0 if peek_idx ≥ DEPTH.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.
- err_trap  out  1  one-cycle pulse on the first ovf/unf set since the last clear.
- err_clr  in  1  clear ovf, unf and the trap arm.
- hwm  out  $clog2(DEPTH+1)  maximum count reached since the last clear.
- hwm_clr  in  1  set hwm <= count.

Behaviour:
- Reset (rst==0 at an edge):
  - all stk entries = 0; count = 0; ovf = unf = err_trap = 0; hwm = 0; trap armed.
  - Reset overrides every other input in that cycle.
- Operation decode, one cycle, applied at the edge:
  - push&~pop: shift down, stk[0] <= load ? data_in : stk[0] (duplicate top when load=0). count+1.
  - pop&~push: shift up, stk[DEPTH-1] <= 0, stk[0] <= load ? data_in : stk[1]. count-1. pop+load is the binary-op form.
  - push&pop: no shift; behaves as load-only; count unchanged; no error raised.
  - load only: stk[0] <= data_in; count unchanged. If count==0, count <= 1.
  - none: hold.
- Overflow (push&~pop with count==DEPTH):
  - Shift still occurs; old stk[DEPTH-1] is discarded.
  - count stays at DEPTH; ovf <= 1.
- Underflow (pop&~push with count==0):
  - Shift still occurs (entries are all 0 beyond valid data).
  - count stays 0; unf <= 1.
- Pop with count==1: count <= 0 and empty asserts next cycle. A simultaneous load sets count to 1 instead.
- err_trap:
  - Asserted for exactly the cycle after the edge at which ovf or unf first becomes 1 while the trap is armed; trap is then disarmed.
  - Further errors keep the flags set without a new pulse.
  - err_clr in the same cycle as a new error: the error wins; the flag is set and pulses if armed, and err_clr only re-arms.
- hwm:
  - Updated each edge to max(hwm, next count).
  - hwm_clr loads the next count; it wins over the max update.
- Flags:
  - full/empty are decoded from registered count (no same-cycle look-ahead).
  - data0/data1/peek_data have zero latency from the register state.
- Widths: count arithmetic saturates and never wraps. No arithmetic is performed on entry data.

Decomposition:
- Shared package (common include): constant ST_OP_* encodings for {push,pop,load} combinations, and function clog2_depth helper.
- One sub-module: stack_ctr (count, full/empty, ovf/unf, trap arm, hwm). The entry shift array stays in eval_stack.

Test Plan:
- Reset then push 1,2,3 with load (data_in=1,2,3) -> data0=3, data1=2, count=3, peek_idx=2 gives 1, empty=0.
- From that state, pop+load data_in=5 -> data0=5, data1=1, count=2; pop,pop -> count=0, empty=1, unf=0.
- DEPTH=4: five push+load of 10..14 -> count=4, full=1, ovf=1, err_trap high one cycle only, peek_idx=3 gives 11.
- Pop on empty -> unf=1, trap pulses once. Second pop on empty -> no new pulse. err_clr then pop on empty -> new pulse.
- push&pop&load data_in=7 with count=2 -> data0=7, data1 unchanged, count=2, no flags.
- Push to count=3, pop to 1 -> hwm=3. hwm_clr -> hwm=1. Assert rst=0 mid-sequence -> all outputs return to reset values next edge.
